// File: rtl/eth_framer_fcs.sv
// Byte-wide Ethernet framer: preamble/SFD, MAC header, optional 802.1Q tag,
// payload pass-through, zero pad to minimum length, CRC-32 FCS and inter-frame gap.
module eth_framer_fcs #(
    parameter bit PREAMBLE_EN      = 1'b1,
    parameter bit VLAN_EN          = 1'b0,
    parameter bit FCS_EN           = 1'b1,
    parameter int MIN_FRAME_OCTETS = 60,
    parameter int IFG_OCTETS       = 12
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [15:0] ethertype,
    input  logic [15:0] vlan_tci,
    output logic        payload_axis_tready,
    input  logic        payload_axis_tvalid,
    input  logic        payload_axis_tlast,
    input  logic [7:0]  payload_axis_tdata,
    input  logic        out_axis_tready,
    output logic        out_axis_tvalid,
    output logic        out_axis_tlast,
    output logic [7:0]  out_axis_tdata
);
    localparam int          HDR_LEN    = VLAN_EN ? 18 : 14;
    localparam logic [10:0] C_HDR_LAST = 11'(HDR_LEN - 1);
    localparam logic [10:0] C_IFG_LAST = 11'(IFG_OCTETS - 1);
    localparam logic [10:0] C_SAT      = 11'h7FF;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_HDR, S_PAYLOAD, S_PAD, S_FCS, S_IFG
    } state_t;

    localparam state_t S_START = PREAMBLE_EN ? S_PRE : S_HDR;
    localparam state_t S_AFTER = (IFG_OCTETS > 0) ? S_IFG : S_IDLE;

    state_t       r_state, w_state_next;
    logic [10:0]  r_cnt, w_cnt_next;
    logic [10:0]  r_fcnt, w_fcnt_next, w_fcnt_inc;
    logic [31:0]  r_crc, w_crc_next, w_fcs;
    logic [47:0]  r_dst, r_src;
    logic [15:0]  r_etype, r_tci;
    logic         w_latch, w_short;
    logic         w_out_valid, w_out_last, w_pay_ready;
    logic [7:0]   w_out_data, w_hdr_byte, w_fcs_byte;
    logic [143:0] w_hdr_vec;
    logic [7:0]   w_hdr_bytes [32];

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ data[i];
            c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0000_0000);
        end
        return c;
    endfunction

    // Header left-aligned so byte i of the wire order is always at the same slice.
    assign w_hdr_vec = VLAN_EN ? {r_dst, r_src, 16'h8100, r_tci, r_etype}
                               : {r_dst, r_src, r_etype, 32'h0000_0000};

    for (genvar gi = 0; gi < 32; gi++) begin : g_hdr_byte
        if (gi < 18) begin : g_used
            assign w_hdr_bytes[gi] = w_hdr_vec[143 - 8*gi -: 8];
        end else begin : g_unused
            assign w_hdr_bytes[gi] = 8'h00;
        end
    end

    assign w_hdr_byte = w_hdr_bytes[r_cnt[4:0]];
    assign w_fcs      = ~r_crc;
    assign w_fcs_byte = w_fcs[{r_cnt[1:0], 3'b000} +: 8];
    assign w_fcnt_inc = (r_fcnt == C_SAT) ? r_fcnt : r_fcnt + 11'd1;
    // Frame still short once the beat being offered is counted.
    assign w_short    = (int'(w_fcnt_inc) < MIN_FRAME_OCTETS);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_fcnt  <= '0;
            r_crc   <= '1;
            r_dst   <= '0;
            r_src   <= '0;
            r_etype <= '0;
            r_tci   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_fcnt  <= w_fcnt_next;
            r_crc   <= w_crc_next;
            if (w_latch) begin
                r_dst   <= dst_mac;
                r_src   <= src_mac;
                r_etype <= ethertype;
                r_tci   <= vlan_tci;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_fcnt_next  = r_fcnt;
        w_crc_next   = r_crc;
        w_latch      = 1'b0;
        w_out_valid  = 1'b0;
        w_out_last   = 1'b0;
        w_out_data   = 8'h00;
        w_pay_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next  = '0;
                w_fcnt_next = '0;
                w_crc_next  = '1;
                if (payload_axis_tvalid) begin
                    w_latch      = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_PRE: begin
                w_out_valid = 1'b1;
                w_out_data  = 8'h55;
                if (out_axis_tready) begin
                    if (r_cnt == 11'd6) begin
                        w_cnt_next   = '0;
                        w_state_next = S_SFD;
                    end else begin
                        w_cnt_next = r_cnt + 11'd1;
                    end
                end
            end
            S_SFD: begin
                w_out_valid = 1'b1;
                w_out_data  = 8'hD5;
                if (out_axis_tready) begin
                    w_cnt_next   = '0;
                    w_state_next = S_HDR;
                end
            end
            S_HDR: begin
                w_out_valid = 1'b1;
                w_out_data  = w_hdr_byte;
                if (out_axis_tready) begin
                    w_crc_next  = crc32_byte(r_crc, w_hdr_byte);
                    w_fcnt_next = w_fcnt_inc;
                    if (r_cnt == C_HDR_LAST) begin
                        w_cnt_next   = '0;
                        w_state_next = S_PAYLOAD;
                    end else begin
                        w_cnt_next = r_cnt + 11'd1;
                    end
                end
            end
            S_PAYLOAD: begin
                w_out_valid = payload_axis_tvalid;
                w_out_data  = payload_axis_tdata;
                w_pay_ready = out_axis_tready;
                w_out_last  = payload_axis_tvalid && payload_axis_tlast && !FCS_EN && !w_short;
                if (payload_axis_tvalid && out_axis_tready) begin
                    w_crc_next  = crc32_byte(r_crc, payload_axis_tdata);
                    w_fcnt_next = w_fcnt_inc;
                    if (payload_axis_tlast) begin
                        w_cnt_next = '0;
                        if (w_short)
                            w_state_next = S_PAD;
                        else if (FCS_EN)
                            w_state_next = S_FCS;
                        else
                            w_state_next = S_AFTER;
                    end
                end
            end
            S_PAD: begin
                w_out_valid = 1'b1;
                w_out_last  = !FCS_EN && !w_short;
                if (out_axis_tready) begin
                    w_crc_next  = crc32_byte(r_crc, 8'h00);
                    w_fcnt_next = w_fcnt_inc;
                    if (!w_short) begin
                        w_cnt_next = '0;
                        if (FCS_EN)
                            w_state_next = S_FCS;
                        else
                            w_state_next = S_AFTER;
                    end
                end
            end
            S_FCS: begin
                w_out_valid = 1'b1;
                w_out_data  = w_fcs_byte;
                w_out_last  = (r_cnt[1:0] == 2'd3);
                if (out_axis_tready) begin
                    if (r_cnt[1:0] == 2'd3) begin
                        w_cnt_next   = '0;
                        w_state_next = S_AFTER;
                    end else begin
                        w_cnt_next = r_cnt + 11'd1;
                    end
                end
            end
            S_IFG: begin
                w_fcnt_next = '0;
                w_crc_next  = '1;
                // The last gap cycle doubles as the idle sample so back-to-back frames keep the exact gap.
                if (r_cnt == C_IFG_LAST) begin
                    w_cnt_next = '0;
                    if (payload_axis_tvalid) begin
                        w_latch      = 1'b1;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + 11'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign out_axis_tvalid     = w_out_valid;
    assign out_axis_tlast      = w_out_last;
    assign out_axis_tdata      = w_out_data;
    assign payload_axis_tready = w_pay_ready;

endmodule

// File: tb/tb_eth_framer_fcs.sv
// Directed scoreboard bench for eth_framer_fcs: default, VLAN and stripped-down configurations.
module tb_eth_framer_fcs;
    logic        clk = 1'b0;
    logic        aresetn;
    logic [47:0] dst, src;
    logic [15:0] etype, tci;
    logic        pv [3];
    logic        pl [3];
    logic [7:0]  pd [3];
    logic        ordy [3];
    logic        ptr [3];
    logic        ov [3];
    logic        ol [3];
    logic [7:0]  od [3];

    int checks = 0;
    int errors = 0;

    // Expected entries: {is_payload, last, data}; payload entries: {last, data}.
    logic [9:0] exp_q [$];
    logic [8:0] pay_q [$];
    logic [7:0] pbytes [$];

    always #5 clk = ~clk;

    eth_framer_fcs u_dflt (
        .clk(clk), .aresetn(aresetn), .dst_mac(dst), .src_mac(src), .ethertype(etype), .vlan_tci(tci),
        .payload_axis_tready(ptr[0]), .payload_axis_tvalid(pv[0]), .payload_axis_tlast(pl[0]),
        .payload_axis_tdata(pd[0]), .out_axis_tready(ordy[0]), .out_axis_tvalid(ov[0]),
        .out_axis_tlast(ol[0]), .out_axis_tdata(od[0]));

    eth_framer_fcs #(.VLAN_EN(1'b1)) u_vlan (
        .clk(clk), .aresetn(aresetn), .dst_mac(dst), .src_mac(src), .ethertype(etype), .vlan_tci(tci),
        .payload_axis_tready(ptr[1]), .payload_axis_tvalid(pv[1]), .payload_axis_tlast(pl[1]),
        .payload_axis_tdata(pd[1]), .out_axis_tready(ordy[1]), .out_axis_tvalid(ov[1]),
        .out_axis_tlast(ol[1]), .out_axis_tdata(od[1]));

    eth_framer_fcs #(.PREAMBLE_EN(1'b0), .FCS_EN(1'b0), .IFG_OCTETS(0), .MIN_FRAME_OCTETS(0)) u_corner (
        .clk(clk), .aresetn(aresetn), .dst_mac(dst), .src_mac(src), .ethertype(etype), .vlan_tci(tci),
        .payload_axis_tready(ptr[2]), .payload_axis_tvalid(pv[2]), .payload_axis_tlast(pl[2]),
        .payload_axis_tdata(pd[2]), .out_axis_tready(ordy[2]), .out_axis_tvalid(ov[2]),
        .out_axis_tlast(ol[2]), .out_axis_tdata(od[2]));

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic set_hdr(input int which);
        if (which == 0) begin
            dst = 48'hFFFF_FFFF_FFFF; src = 48'h0200_0000_0001; etype = 16'h0800; tci = 16'h0123;
        end else begin
            dst = 48'h0A1B_2C3D_4E5F; src = 48'h0200_0000_0002; etype = 16'h86DD; tci = 16'h0456;
        end
    endtask

    // Reference frame builder for the configuration of instance sel, payload from pbytes.
    task automatic add_frame(input int sel, input logic [47:0] d, input logic [47:0] s,
                             input logic [15:0] et, input logic [15:0] t);
        logic [7:0]  fb [$];
        logic [31:0] crc;
        int          hlen, minf, plen;
        bit          pre, vl, fcs;
        pre  = (sel != 2);
        vl   = (sel == 1);
        fcs  = (sel != 2);
        minf = (sel == 2) ? 0 : 60;
        plen = pbytes.size();
        fb   = {};
        for (int i = 0; i < 6; i++) fb.push_back(d[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) fb.push_back(s[47-8*i -: 8]);
        if (vl) begin
            fb.push_back(8'h81); fb.push_back(8'h00); fb.push_back(t[15:8]); fb.push_back(t[7:0]);
        end
        fb.push_back(et[15:8]); fb.push_back(et[7:0]);
        hlen = fb.size();
        for (int i = 0; i < plen; i++) begin
            fb.push_back(pbytes[i]);
            pay_q.push_back({(i == plen - 1), pbytes[i]});
        end
        while (fb.size() < minf) fb.push_back(8'h00);
        crc = 32'hFFFF_FFFF;
        foreach (fb[i]) crc = crc_upd(crc, fb[i]);
        crc = ~crc;
        if (pre) begin
            for (int i = 0; i < 7; i++) exp_q.push_back({2'b00, 8'h55});
            exp_q.push_back({2'b00, 8'hD5});
        end
        foreach (fb[i])
            exp_q.push_back({(i >= hlen && i < hlen + plen), (!fcs && i == fb.size() - 1), fb[i]});
        if (fcs)
            for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, (k == 3), crc[8*k +: 8]});
    endtask

    // Drives queued payload into instance sel and scores its output until the queue drains.
    task automatic run(input int sel, input bit rnd, input int chg_at, input int rst_at,
                       input int gmin, input int gmax, input int exp_beats);
        int         beats = 0, cyc = 0, gap = 0, accepted = 0;
        bit         after_last = 1'b0;
        logic [9:0] e;
        while (exp_q.size() > 0 && cyc < 3000) begin
            if (beats == chg_at) set_hdr(1);
            ordy[sel] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pv[sel]   = (pay_q.size() > 0);
            pd[sel]   = (pay_q.size() > 0) ? pay_q[0][7:0] : 8'h00;
            pl[sel]   = (pay_q.size() > 0) ? pay_q[0][8] : 1'b0;
            #4;
            if (rst_at >= 0 && accepted == rst_at) begin
                chk("pre_reset_valid", 48'(ov[sel]), 48'(1));
                aresetn = 1'b0;
                #1;
                chk("reset_valid", 48'(ov[sel]), 48'(0));
                chk("reset_ptready", 48'(ptr[sel]), 48'(0));
                chk("reset_last", 48'(ol[sel]), 48'(0));
                $display("run dut=%0d truncated by reset after %0d payload bytes", sel, accepted);
                return;
            end
            chk("ptready", 48'(ptr[sel]), 48'(ordy[sel] & exp_q[0][9]));
            if (ov[sel] && after_last) begin
                chk("ifg_gap", 48'(gap >= gmin && gap <= gmax), 48'(1));
                after_last = 1'b0;
            end else if (!ov[sel] && after_last) begin
                gap++;
            end
            if (ov[sel] && ordy[sel]) begin
                e = exp_q.pop_front();
                chk("data", 48'(od[sel]), 48'(e[7:0]));
                chk("last", 48'(ol[sel]), 48'(e[8]));
                beats++;
                if (e[8]) begin
                    after_last = 1'b1;
                    gap = 0;
                end
            end
            if (pv[sel] && ptr[sel]) begin
                void'(pay_q.pop_front());
                accepted++;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        pv[sel]   = 1'b0;
        pl[sel]   = 1'b0;
        ordy[sel] = 1'b1;
        chk("drained", 48'(exp_q.size()), 48'(0));
        chk("beats", 48'(beats), 48'(exp_beats));
        $display("run dut=%0d beats=%0d cycles=%0d", sel, beats, cyc);
    endtask

    initial begin
        aresetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0; pl[i] = 1'b0; pd[i] = 8'h00; ordy[i] = 1'b1;
        end
        pv[0] = 1'b1;
        set_hdr(0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_tvalid", 48'(ov[i]), 48'(0));
            chk("rst_tlast", 48'(ol[i]), 48'(0));
            chk("rst_tdata", 48'(od[i]), 48'(0));
            chk("rst_ptready", 48'(ptr[i]), 48'(0));
        end
        pv[0] = 1'b0;
        aresetn = 1'b1;
        @(posedge clk);
        #1;

        // Minimal frame, defaults
        pbytes = {8'hAB};
        add_frame(0, 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 16'h0123);
        run(0, 1'b0, -1, -1, 0, 0, 72);

        // 100-byte incrementing payload under random backpressure
        pbytes = {};
        for (int i = 0; i < 100; i++) pbytes.push_back(8'(i));
        add_frame(0, 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 16'h0123);
        run(0, 1'b1, -1, -1, 0, 0, 126);

        // VLAN-tagged minimal frame
        pbytes = {8'hAB};
        add_frame(1, 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 16'h0123);
        run(1, 1'b0, -1, -1, 0, 0, 72);

        // Back-to-back frames, header inputs switched during frame 1
        pbytes = {8'hAB};
        add_frame(0, 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 16'h0123);
        pbytes = {8'h5A, 8'hC3};
        add_frame(0, 48'h0A1B_2C3D_4E5F, 48'h0200_0000_0002, 16'h86DD, 16'h0456);
        run(0, 1'b0, 10, -1, 12, 12, 144);
        set_hdr(0);
        repeat (14) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of the payload
        pbytes = {};
        for (int i = 0; i < 10; i++) pbytes.push_back(8'(8'h10 + i));
        add_frame(0, 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 16'h0123);
        run(0, 1'b0, -1, 5, 0, 0, 0);
        exp_q.delete();
        pay_q.delete();
        pv[0] = 1'b0;
        pl[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("held_reset_valid", 48'(ov[0]), 48'(0));
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        pbytes = {8'hAB};
        add_frame(0, 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 16'h0123);
        run(0, 1'b0, -1, -1, 0, 0, 72);

        // Stripped configuration: no preamble, no FCS, no gap, no minimum
        pbytes = {8'h01, 8'h02, 8'h03};
        add_frame(2, 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 16'h0123);
        run(2, 1'b0, -1, -1, 0, 1, 17);
        pbytes = {8'h11, 8'h22, 8'h33};
        add_frame(2, 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 16'h0123);
        pbytes = {8'h44, 8'h55, 8'h66};
        add_frame(2, 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 16'h0123);
        run(2, 1'b0, -1, -1, 0, 1, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
